dac_stream_buffer: RTL and testbench

- Elastic AXI-stream buffer between tx_core's dac_tdata/dac_tvalid output and the RF-DAC AXI-stream input.
- tx_core drives tvalid continuously and ignores tready, so this block absorbs backpressure from the DAC.
- It primes before streaming, mutes the DAC with zero words on underflow or when disabled, and counts dropped (overflow) and starved (underflow) beats for debug.

---
 rtl/dac_stream_pkg.sv | 18 +
 rtl/dac_stream_fifo_mem.sv | 29 ++
 rtl/dac_stream_buffer.sv | 152 +++++++++++++++
 tb/tb_dac_stream_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_stream_pkg.sv
// Shared types and constants for the DAC stream buffer: FSM state encoding,
// default beat geometry and debug counter sizing.
package dac_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int DEF_SAMPLE_WIDTH   = 16;
  localparam int DEF_NUMBER_OF_LINE = 8;
  localparam int BEAT_WIDTH         = 2 * DEF_SAMPLE_WIDTH * DEF_NUMBER_OF_LINE;

  localparam int                     COUNT_WIDTH = 16;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

endpackage

// File: rtl/dac_stream_fifo_mem.sv
// Beat storage for the DAC stream buffer: one write port and one registered
// read port; all pointer and flow control lives in the parent.
module dac_stream_fifo_mem
  import dac_stream_pkg::*;
#(
  parameter int WIDTH = BEAT_WIDTH,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dac_stream_buffer.sv
// Elastic buffer between tx_core and the RF-DAC: primes to a fill threshold,
// streams on DAC ready, mutes with zero words when starved or disabled.
module dac_stream_buffer
  import dac_stream_pkg::*;
#(
  parameter int NUMBER_OF_LINE = DEF_NUMBER_OF_LINE,
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH     = 16,
  parameter int PREFILL_LEVEL  = 8
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic                                   enable,
  input  logic [2*SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] s_tdata,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  output logic [2*SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] m_tdata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  input  logic                                   clear_counters,
  output logic [$clog2(FIFO_DEPTH):0]            fill_level,
  output logic [COUNT_WIDTH-1:0]                 overflow_count,
  output logic [COUNT_WIDTH-1:0]                 underflow_count,
  output logic [1:0]                             state_dbg
);

  localparam int             BW          = 2 * SAMPLE_WIDTH * NUMBER_OF_LINE;
  localparam int             AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    PTR_ONE     = (AW+1)'(1);
  localparam logic [AW:0]    PREFILL_THR = (AW+1)'(PREFILL_LEVEL);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                     input logic                   inc);
    return (inc && (v != COUNT_MAX)) ? v + COUNT_WIDTH'(1) : v;
  endfunction

  state_t                 r_state;
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic                   r_mute;
  logic                   r_m_tvalid;
  logic [COUNT_WIDTH-1:0] r_ovf_cnt;
  logic [COUNT_WIDTH-1:0] r_unf_cnt;

  logic [BW-1:0]          w_rd_data;
  logic [AW:0]            w_fill;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_active;
  logic                   w_run;
  logic                   w_wr_en;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_starve;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign w_fill   = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_active = enable && ((r_state == PREFILL) || (r_state == RUN));
  assign w_run    = enable && (r_state == RUN) && m_tready;
  assign w_wr_en  = w_active && s_tvalid && !w_full;
  assign w_drop   = w_active && s_tvalid && w_full;
  assign w_pop    = w_run && !w_empty;
  assign w_starve = w_run && w_empty;

  dac_stream_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clock   (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (s_tdata),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mute     <= 1'b1;
      r_m_tvalid <= 1'b0;
    end else begin
      r_m_tvalid <= 1'b1;
      if (!enable) begin
        r_state  <= IDLE;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_mute   <= 1'b1;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case (r_state)
          IDLE: begin
            r_state  <= PREFILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mute   <= 1'b1;
          end
          PREFILL: begin
            r_mute <= 1'b1;
            if (w_fill >= PREFILL_THR) r_state <= RUN;
          end
          RUN: begin
            // Starving re-primes the buffer rather than trickling single beats.
            if (w_pop) begin
              r_mute <= 1'b0;
            end else if (w_starve) begin
              r_mute  <= 1'b1;
              r_state <= PREFILL;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mute   <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (clear_counters) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      r_ovf_cnt <= sat_inc(r_ovf_cnt, w_drop);
      r_unf_cnt <= sat_inc(r_unf_cnt, w_starve);
    end
  end

  // Muting gates the read register so the DAC sees zeros without a data reset.
  assign m_tdata         = r_mute ? '0 : w_rd_data;
  assign m_tvalid        = r_m_tvalid;
  assign s_tready        = !w_full;
  assign fill_level      = w_fill;
  assign overflow_count  = r_ovf_cnt;
  assign underflow_count = r_unf_cnt;
  assign state_dbg       = r_state;

endmodule

// File: tb/tb_dac_stream_buffer.sv
// Bench for dac_stream_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dac_stream_buffer;
  import dac_stream_pkg::*;

  localparam int BW      = BEAT_WIDTH;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;

  logic          clock;
  logic          resetn;
  logic          enable;
  logic [BW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          clear_counters;
  logic [4:0]    fill_level;
  logic [15:0]   overflow_count;
  logic [15:0]   underflow_count;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  dac_stream_buffer #(
    .NUMBER_OF_LINE (8),
    .SAMPLE_WIDTH   (16),
    .FIFO_DEPTH     (DEPTH),
    .PREFILL_LEVEL  (PREFILL)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .clear_counters  (clear_counters),
    .fill_level      (fill_level),
    .overflow_count  (overflow_count),
    .underflow_count (underflow_count),
    .state_dbg       (state_dbg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [BW-1:0] beat(input int k);
    logic [15:0] s;
    s = k[15:0];
    return {16{s}};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of beats, a three-state mode and two counters.
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_out;
  logic          m_valid;
  int            m_state;
  int            m_ovf;
  int            m_unf;

  task automatic model_reset();
    mq.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_state = 0;
    m_ovf   = 0;
    m_unf   = 0;
  endtask

  task automatic model_step();
    int fill;
    bit push, drop, starve;
    fill   = mq.size();
    push   = 0;
    drop   = 0;
    starve = 0;
    m_valid = 1'b1;
    if (!enable) begin
      mq.delete();
      m_state = 0;
      m_out   = '0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_out   = '0;
    end else begin
      if (s_tvalid) begin
        if (fill < DEPTH) push = 1;
        else drop = 1;
      end
      if (m_state == 1) begin
        m_out = '0;
        if (fill >= PREFILL) m_state = 2;
      end else if (m_tready) begin
        if (fill > 0) m_out = mq.pop_front();
        else begin
          m_out   = '0;
          starve  = 1;
          m_state = 1;
        end
      end
      if (push) mq.push_back(s_tdata);
    end
    if (clear_counters) begin
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (drop && m_ovf < 65535) m_ovf++;
      if (starve && m_unf < 65535) m_unf++;
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    if (resetn) begin
      check("cyc_m_tdata", m_tdata, m_out);
      check("cyc_m_tvalid", BW'(m_tvalid), BW'(m_valid));
      check("cyc_s_tready", BW'(s_tready), BW'(mq.size() < DEPTH));
      check("cyc_fill", BW'(fill_level), BW'(mq.size()));
      check("cyc_state", BW'(state_dbg), BW'(m_state));
      check("cyc_ovf", BW'(overflow_count), BW'(m_ovf));
      check("cyc_unf", BW'(underflow_count), BW'(m_unf));
    end
  end

  initial begin
    resetn         = 1'b1;
    enable         = 1'b0;
    s_tvalid       = 1'b1;
    s_tdata        = beat(5);
    m_tready       = 1'b0;
    clear_counters = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_m_tvalid", BW'(m_tvalid), '0);
    check("rst_s_tready", BW'(s_tready), BW'(1));
    check("rst_fill", BW'(fill_level), '0);
    check("rst_state", BW'(state_dbg), '0);

    resetn = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_m_tvalid", BW'(m_tvalid), BW'(1));
    check("idle_state", BW'(state_dbg), '0);
    check("idle_fill", BW'(fill_level), '0);
    check("idle_ovf", BW'(overflow_count), '0);

    // Continuous stream with DAC always ready.
    s_tvalid = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;
    @(negedge clock);
    check("pf_state", BW'(state_dbg), BW'(1));
    for (int k = 0; k < 32; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat(k);
      @(negedge clock);
      if (k == 7) begin
        check("pf_fill8", BW'(fill_level), BW'(8));
        check("pf_hold", BW'(state_dbg), BW'(1));
      end
      if (k == 8)  check("run_entry", BW'(state_dbg), BW'(2));
      if (k == 12) check("order_b3", m_tdata, beat(3));
      if (k == 31) check("order_b22", m_tdata, beat(22));
    end
    s_tvalid = 1'b0;
    repeat (12) @(negedge clock);
    check("drain_state", BW'(state_dbg), BW'(1));
    check("drain_unf", BW'(underflow_count), BW'(1));
    check("stream_ovf", BW'(overflow_count), '0);
    check("drain_mute", m_tdata, '0);

    // Disable with a counter clear, then overflow with the DAC stalled.
    enable         = 1'b0;
    clear_counters = 1'b1;
    @(negedge clock);
    check("dis_state", BW'(state_dbg), '0);
    check("clr_unf", BW'(underflow_count), '0);
    enable         = 1'b1;
    clear_counters = 1'b0;
    m_tready       = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 20; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat(k);
      @(negedge clock);
    end
    s_tvalid = 1'b0;
    check("full_fill", BW'(fill_level), BW'(16));
    check("full_s_tready", BW'(s_tready), '0);
    check("full_ovf", BW'(overflow_count), BW'(4));
    check("full_state", BW'(state_dbg), BW'(2));

    m_tready = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clock);
      if (j == 5) check("ovf_order_b5", m_tdata, beat(5));
    end
    m_tready = 1'b0;
    check("fill3", BW'(fill_level), BW'(3));
    check("pop_b12", m_tdata, beat(12));
    @(negedge clock);
    check("hold_b12", m_tdata, beat(12));

    // Starve from three beats, then re-prime.
    m_tready = 1'b1;
    repeat (3) @(negedge clock);
    check("tail_b15", m_tdata, beat(15));
    @(negedge clock);
    check("unf_mute", m_tdata, '0);
    check("unf_count", BW'(underflow_count), BW'(1));
    check("unf_state", BW'(state_dbg), BW'(1));
    for (int i = 0; i < 13; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat(100 + i);
      @(negedge clock);
      if (i == 7) check("refill_pf", BW'(state_dbg), BW'(1));
      if (i == 8) check("refill_run", BW'(state_dbg), BW'(2));
      if (i == 9) check("refill_b100", m_tdata, beat(100));
    end
    s_tvalid = 1'b0;
    repeat (4) @(negedge clock);
    m_tready = 1'b0;
    check("fill5", BW'(fill_level), BW'(5));
    check("fill5_b107", m_tdata, beat(107));

    // One-cycle disable flushes the buffer; no stale beat may resurface.
    enable = 1'b0;
    @(negedge clock);
    check("flush_state", BW'(state_dbg), '0);
    check("flush_fill", BW'(fill_level), '0);
    check("flush_mute", m_tdata, '0);
    enable   = 1'b1;
    m_tready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat(200 + i);
      @(negedge clock);
      if (i == 8) check("reen_mute", m_tdata, '0);
      if (i == 9) check("reen_b200", m_tdata, beat(200));
    end

    // Overflow counter saturation and clear priority.
    m_tready       = 1'b0;
    s_tdata        = beat(300);
    clear_counters = 1'b1;
    repeat (10) @(negedge clock);
    check("sat_fill", BW'(fill_level), BW'(16));
    check("sat_clr0", BW'(overflow_count), '0);
    clear_counters = 1'b0;
    repeat (65534) @(negedge clock);
    check("sat_fffe", BW'(overflow_count), BW'(16'hFFFE));
    repeat (3) @(negedge clock);
    check("sat_ffff", BW'(overflow_count), BW'(16'hFFFF));
    clear_counters = 1'b1;
    @(negedge clock);
    check("clr_wins", BW'(overflow_count), '0);
    clear_counters = 1'b0;
    @(negedge clock);
    check("ovf_after_clr", BW'(overflow_count), BW'(1));
    check("held_b202", m_tdata, beat(202));

    // Asynchronous reset mid-stream.
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_m_tdata", m_tdata, '0);
    check("mid_rst_m_tvalid", BW'(m_tvalid), '0);
    check("mid_rst_fill", BW'(fill_level), '0);
    check("mid_rst_s_tready", BW'(s_tready), BW'(1));
    check("mid_rst_state", BW'(state_dbg), '0);
    check("mid_rst_ovf", BW'(overflow_count), '0);
    @(negedge clock);
    resetn   = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
